// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, PC/register-relative jumps,
// call/return via a circular return-address stack, trap/rti and halt.
module pc_sequencer #(
    parameter int                 WIDTH     = 16,
    parameter int                 INC       = 2,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   TRAP_VEC  = WIDTH'(16'h0002),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs,
    input  logic             br_take,
    input  logic             reg_jmp,
    input  logic             call,
    input  logic             ret,
    input  logic             trap,
    input  logic             rti,
    input  logic             stall,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] epc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             err
);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             err_q, err_d;
    logic             halted_q;
    logic [PW-1:0]    top_q, top_d, top_inc;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             push, pop, illegal;
    logic [2:0]       nsel;

    assign pc_inc    = pc_q + WIDTH'(INC);
    assign top_inc   = top_q + PW'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
    assign nsel      = 3'(br_take) + 3'(reg_jmp) + 3'(ret) + 3'(rti);
    assign illegal   = (nsel > 3'd1) || (call && ret);

    always_comb begin
        pc_d    = pc_inc;
        epc_d   = epc_q;
        state_d = state_q;
        err_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == HALTED) begin
            pc_d = pc_q;
        end else begin
            err_d = illegal;
            if (halt) begin
                pc_d    = pc_q;
                state_d = HALTED;
            end else if (trap) begin
                pc_d  = TRAP_VEC;
                epc_d = pc_inc;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (rti) begin
                pc_d = epc_q;
            end else if (ret) begin
                // ret wins over call, so a ret+call pair only pops
                if (!ras_empty) begin
                    pc_d = ras_q[top_q];
                    pop  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (reg_jmp)      pc_d = rs + imm;
                else if (br_take) pc_d = pc_inc + imm;
                push = call;
            end
        end
        if (rst) pc_d = RESET_VEC;
    end

    assign pc_next = pc_d;

    // A full stack keeps its count; the write lands on the oldest slot.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            top_d = top_inc;
            if (!ras_full) cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_VEC;
            epc_q    <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            top_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            err_q    <= err_d;
            halted_q <= (state_d == HALTED);
            top_q    <= top_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) ras_q[top_inc] <= pc_inc;
    end

    assign pc     = pc_q;
    assign epc    = epc_q;
    assign halted = halted_q;
    assign err    = err_q;
endmodule
